// File: rtl/lru_victim_allocator.sv
// rtl/lru_victim_allocator.sv - entry valid bits, victim selection and access arbitration for an LRU tracker
// lru_idx is trusted only once settle_cnt has drained after the last issued touch.
module lru_victim_allocator #(
  parameter int NO_ENTRY   = 8,
  parameter int IDX_WIDTH  = $clog2(NO_ENTRY),
  parameter int SETTLE_CYC = NO_ENTRY / 2 + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hit_en,
  input  logic [IDX_WIDTH-1:0] hit_idx,
  input  logic                 inval_en,
  input  logic [IDX_WIDTH-1:0] inval_idx,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic [IDX_WIDTH-1:0] alloc_idx,
  output logic                 acc_en,
  output logic [IDX_WIDTH-1:0] acc_idx,
  input  logic [IDX_WIDTH-1:0] lru_idx,
  output logic [NO_ENTRY-1:0]  valid_vec,
  output logic                 busy
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT} state_t;

  state_t               state, state_d;
  logic [CNT_W-1:0]     settle_cnt, settle_d;
  logic [NO_ENTRY-1:0]  valid_d;
  logic                 gnt_d, acc_en_d, busy_d;
  logic [IDX_WIDTH-1:0] alloc_idx_d, acc_idx_d;
  logic                 hit_ok, accept, free_found;
  logic [IDX_WIDTH-1:0] free_idx, victim;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NO_ENTRY - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_WIDTH'(i);
      end
    end
  end

  always_comb begin
    // an invalidate of the same entry in the same cycle cancels the touch
    hit_ok = hit_en && valid_vec[hit_idx] && !(inval_en && (inval_idx == hit_idx));
    victim = free_found ? free_idx : lru_idx;
    accept = (state == IDLE) && alloc_req && (settle_cnt == '0) && !hit_en && !hit_ok;

    acc_en_d    = accept || hit_ok;
    acc_idx_d   = acc_idx;
    if (accept)      acc_idx_d = victim;
    else if (hit_ok) acc_idx_d = hit_idx;

    gnt_d       = accept;
    alloc_idx_d = accept ? victim : alloc_idx;

    if (acc_en_d)                settle_d = CNT_W'(SETTLE_CYC);
    else if (settle_cnt != '0)   settle_d = settle_cnt - CNT_W'(1);
    else                         settle_d = '0;

    valid_d = valid_vec;
    if (inval_en) valid_d[inval_idx] = 1'b0;
    if (accept)   valid_d[victim]    = 1'b1;

    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = GRANT;
      GRANT:   state_d = WAIT;
      WAIT:    if (settle_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || (settle_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      valid_vec  <= '0;
      alloc_gnt  <= 1'b0;
      alloc_idx  <= '0;
      acc_en     <= 1'b0;
      acc_idx    <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      settle_cnt <= settle_d;
      valid_vec  <= valid_d;
      alloc_gnt  <= gnt_d;
      alloc_idx  <= alloc_idx_d;
      acc_en     <= acc_en_d;
      acc_idx    <= acc_idx_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_lru_victim_allocator.sv
// tb/tb_lru_victim_allocator.sv - self-checking bench for lru_victim_allocator
// Reference model tracks time since the last touch instead of FSM state; a queue emulates the tracker.
module tb_lru_victim_allocator;

  localparam int N = 8;
  localparam int W = 3;
  localparam int S = N / 2 + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         hit_en, inval_en, alloc_req;
  logic [W-1:0] hit_idx, inval_idx, lru_idx;
  logic         alloc_gnt, acc_en, busy;
  logic [W-1:0] alloc_idx, acc_idx;
  logic [N-1:0] valid_vec;

  always #5 clk = ~clk;

  lru_victim_allocator #(.NO_ENTRY(N)) dut (
    .clk(clk), .rst(rst),
    .hit_en(hit_en), .hit_idx(hit_idx),
    .inval_en(inval_en), .inval_idx(inval_idx),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx),
    .acc_en(acc_en), .acc_idx(acc_idx),
    .lru_idx(lru_idx), .valid_vec(valid_vec), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  bit   vm[N];
  int   last_acc, cyc;
  int   order[$];
  bit   e_gnt, e_acc, e_busy;
  int   e_aidx, e_accidx;
  logic [N-1:0] e_valid;

  typedef struct {
    bit req; bit he; int hi; bit ie; int ii;
    bit gnt; int aidx; bit acc; int acci; logic [N-1:0] valid; bit busy;
  } vec_t;
  vec_t vecs[10];

  function automatic int settle_at(int t);
    int d = S - (t - last_acc);
    return (d > 0) ? d : 0;
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (vm[i]) vm[i] = 1'b0;
    last_acc = -100;
    cyc      = 0;
    order    = {};
    for (int i = 0; i < N; i++) order.push_back(i);
    e_gnt = 0; e_acc = 0; e_busy = 0; e_aidx = 0; e_accidx = 0;
  endtask

  // one clock: predict from the inputs now applied, then compare at the next falling edge
  task automatic step();
    bit hok, accept, ok;
    int victim;
    lru_idx = W'(order[0]);
    hok     = hit_en && vm[hit_idx] && !(inval_en && inval_idx == hit_idx);
    accept  = alloc_req && settle_at(cyc) == 0 && !hit_en;
    victim  = -1;
    for (int i = 0; i < N; i++) if (!vm[i] && victim < 0) victim = i;
    if (victim < 0) victim = int'(lru_idx);
    e_gnt    = accept;
    e_acc    = accept || hok;
    e_accidx = accept ? victim : int'(hit_idx);
    if (accept) e_aidx = victim;
    if (inval_en) vm[inval_idx] = 1'b0;
    if (accept)   vm[victim]    = 1'b1;
    cyc++;
    if (e_acc) begin
      last_acc = cyc;
      foreach (order[k]) if (order[k] == e_accidx) begin order.delete(k); break; end
      order.push_back(e_accidx);
    end
    e_busy = settle_at(cyc) != 0;
    for (int i = 0; i < N; i++) e_valid[i] = vm[i];
    @(negedge clk);
    ok = (alloc_gnt == e_gnt) && (acc_en == e_acc) && (valid_vec == e_valid) && (busy == e_busy)
         && (!e_acc || acc_idx == W'(e_accidx)) && (!e_gnt || alloc_idx == W'(e_aidx));
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL model cyc=%0d gnt=%0d/%0d aidx=%0d/%0d acc=%0d/%0d accidx=%0d/%0d valid=%h/%h busy=%0d/%0d",
               cyc, alloc_gnt, e_gnt, alloc_idx, e_aidx, acc_en, e_acc, acc_idx, e_accidx,
               valid_vec, e_valid, busy, e_busy);
    end
  endtask

  task automatic clear_inputs();
    hit_en = 0; hit_idx = 0; inval_en = 0; inval_idx = 0; alloc_req = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    lru_idx = W'(order[0]);
    check("reset_outputs", {alloc_gnt, alloc_idx, acc_en, acc_idx, valid_vec, busy}, 0);
  endtask

  task automatic wait_gnt(input int budget, output int idx, output int waited);
    alloc_req = 1'b1;
    waited = 0;
    do begin
      step();
      waited++;
    end while (!alloc_gnt && waited < budget);
    check("gnt_seen", alloc_gnt, 1);
    idx = int'(alloc_idx);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int idx, waited;
    rst = 1'b1;
    clear_inputs();
    model_reset();
    lru_idx = 0;

    vecs[0] = '{1,0,0,0,0, 1,0,1,0, 8'h01,1};
    vecs[1] = '{0,1,0,0,0, 0,0,1,0, 8'h01,1};
    vecs[2] = '{0,1,6,0,0, 0,0,0,0, 8'h01,1};
    vecs[3] = '{0,1,0,1,0, 0,0,0,0, 8'h00,1};
    vecs[4] = '{0,0,0,0,0, 0,0,0,0, 8'h00,1};
    vecs[5] = '{0,0,0,0,0, 0,0,0,0, 8'h00,1};
    vecs[6] = '{0,0,0,0,0, 0,0,0,0, 8'h00,0};
    vecs[7] = '{0,1,3,0,0, 0,0,0,0, 8'h00,0};
    vecs[8] = '{1,0,0,1,0, 1,0,1,0, 8'h01,1};
    vecs[9] = '{0,0,0,0,0, 0,0,0,0, 8'h01,1};

    do_reset();
    foreach (vecs[i]) begin
      alloc_req = vecs[i].req; hit_en = vecs[i].he; hit_idx = W'(vecs[i].hi);
      inval_en = vecs[i].ie; inval_idx = W'(vecs[i].ii);
      step();
      check($sformatf("vec%0d_gnt", i), alloc_gnt, vecs[i].gnt);
      if (vecs[i].gnt) check($sformatf("vec%0d_aidx", i), alloc_idx, vecs[i].aidx);
      check($sformatf("vec%0d_acc", i), acc_en, vecs[i].acc);
      if (vecs[i].acc) check($sformatf("vec%0d_accidx", i), acc_idx, vecs[i].acci);
      check($sformatf("vec%0d_valid", i), valid_vec, vecs[i].valid);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
    end

    // cold fill: victims in index order, grants SETTLE_CYC+1 apart
    do_reset();
    for (int k = 0; k < N; k++) begin
      wait_gnt(40, idx, waited);
      check($sformatf("fill%0d_idx", k), idx, k);
      if (k > 0) check($sformatf("fill%0d_spacing", k), waited, S + 1);
    end
    alloc_req = 0;
    check("fill_valid", valid_vec, 8'hFF);

    // LRU victim after touching 0 then 2
    hit_en = 1; hit_idx = 0; step();
    hit_idx = 2; step();
    hit_en = 0; idle_steps(6);
    wait_gnt(40, idx, waited);
    check("lru_victim", idx, 1);
    alloc_req = 0; step();
    wait_gnt(40, idx, waited);
    check("lru_victim_next", idx, 3);
    alloc_req = 0;

    // invalid entry preferred over lru_idx
    inval_en = 1; inval_idx = 5; step();
    inval_en = 0;
    wait_gnt(40, idx, waited);
    check("invalid_pref", idx, 5);
    alloc_req = 0; step();
    check("invalid_pref_valid", valid_vec, 8'hFF);
    idle_steps(7);

    // hit collides with request rise
    alloc_req = 1; hit_en = 1; hit_idx = 3; step();
    hit_en = 0;
    check("coll_no_gnt", alloc_gnt, 0);
    check("coll_acc", acc_en, 1);
    check("coll_acc_idx", acc_idx, 3);
    wait_gnt(40, idx, waited);
    check("coll_delay", waited, S + 1);
    alloc_req = 0;

    // hit on invalid entry is dropped
    inval_en = 1; inval_idx = 6; step();
    inval_en = 0; idle_steps(7);
    hit_en = 1; hit_idx = 6; step();
    hit_en = 0;
    check("drop_acc", acc_en, 0);
    check("drop_busy", busy, 0);

    // reset two cycles into WAIT
    do_reset();
    wait_gnt(40, idx, waited);
    alloc_req = 0; step(); step();
    rst = 1'b1;
    #1;
    check("midrst_outputs", {alloc_gnt, acc_en, valid_vec, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    wait_gnt(40, idx, waited);
    check("midrst_regrant", idx, 0);
    alloc_req = 0;

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      hit_en    = ($urandom_range(0, 2) == 0);
      hit_idx   = W'($urandom_range(0, N - 1));
      inval_en  = ($urandom_range(0, 9) == 0);
      inval_idx = W'($urandom_range(0, N - 1));
      if (!alloc_req)  alloc_req = ($urandom_range(0, 3) == 0);
      else if (e_gnt)  alloc_req = ($urandom_range(0, 1) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
